// File: rtl/spi_sub_sync.sv
// rtl/spi_sub_sync.sv - clk-domain SPI subordinate, all CPOL/CPHA modes, optional SPI_SUB_FRAME_ERR_EN
module spi_sub_sync #(
  parameter int DATA_W      = 128,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              sdi,
  output logic              sdo,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
`ifdef SPI_SUB_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              tx_underrun
);

  localparam int            CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);
  localparam logic          IDLE_SCLK = 1'(CPOL);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, sdi_s;
  logic                   cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, sdo_q, sdo_d;
  logic                   underrun_q, underrun_d, pend_q, pend_d, zero_pend_q, zero_pend_d;
  logic                   word_load, frame_start;
`ifdef SPI_SUB_FRAME_ERR_EN
  logic                   frame_err_q, frame_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {SYNC_STAGES{IDLE_SCLK}};
      sdi_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= IDLE_SCLK;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign lead_edge   = (sclk_s ^ sclk_prev_q) & (sclk_s != IDLE_SCLK);
  assign trail_edge  = (sclk_s ^ sclk_prev_q) & (sclk_s == IDLE_SCLK);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    sdo_d       = sdo_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    pend_d      = pend_q;
    zero_pend_d = zero_pend_q;
    word_load   = 1'b0;
    frame_start = 1'b0;
`ifdef SPI_SUB_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d     = S_SHIFT;
          cnt_d       = '0;
          word_load   = 1'b1;
          frame_start = 1'b1;
`ifdef SPI_SUB_FRAME_ERR_EN
          underrun_d  = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          sdo_d       = 1'b0;
          pend_d      = 1'b0;
          zero_pend_d = 1'b0;
          if (cnt_q == CNT_FULL || (sample_edge && cnt_q == CNT_LAST)) begin
            rx_data_d  = (cnt_q == CNT_FULL) ? rx_shift_q : {rx_shift_q[DATA_W-2:0], sdi_s};
            rx_valid_d = 1'b1;
          end
`ifdef SPI_SUB_FRAME_ERR_EN
          else if (cnt_q != '0) frame_err_d = 1'b1;
`endif
        end else begin
          if (cnt_q == CNT_FULL) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            word_load  = 1'b1;
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], sdi_s};
            cnt_d      = cnt_q + 1'b1;
            // an empty burst reload only counts as underrun once the next word really begins
            if (cnt_q == '0 && zero_pend_q) begin
              underrun_d  = 1'b1;
              zero_pend_d = 1'b0;
            end
          end
          if (shift_edge) begin
            if (pend_q) begin
              sdo_d  = shift_q[DATA_W-1];
              pend_d = 1'b0;
            end else begin
              shift_d = {shift_q[DATA_W-2:0], 1'b0};
              sdo_d   = shift_q[DATA_W-2];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (word_load) begin
      shift_d     = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
      pend_d      = !(frame_start && CPHA == 0);
      if (frame_start) begin
        if (CPHA == 0) sdo_d = hold_full_q & hold_q[DATA_W-1];
        if (!hold_full_q) underrun_d = 1'b1;
      end else begin
        zero_pend_d = !hold_full_q;
      end
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sdo_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      pend_q      <= 1'b0;
      zero_pend_q <= 1'b0;
`ifdef SPI_SUB_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      sdo_q       <= sdo_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      pend_q      <= pend_d;
      zero_pend_q <= zero_pend_d;
`ifdef SPI_SUB_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign sdo         = sdo_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == S_SHIFT);
  assign tx_underrun = underrun_q;
`ifdef SPI_SUB_FRAME_ERR_EN
  assign frame_err   = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_sub_sync.sv
// tb/tb_spi_sub_sync.sv - directed bench: four 8-bit modes plus one 128-bit mode-0 instance on a shared bus
module tb_spi_sub_sync;

  logic         clk = 1'b0;
  logic         rst_n, cs, sclk_b, sdi;
  logic [127:0] tx_data_b;
  logic [4:0]   txv, txr, rxv, bsy, und, sdo_all, ferr;
  logic [7:0]   rxd8 [4];
  logic [127:0] rxd128;
  logic [127:0] mis_lead [5];
  logic [127:0] mis_trail [5];
  int           rxv_cnt [5];
  int           ferr_cnt;
  logic [7:0]   rx0_last, rx0_prev;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_m
    logic sck;
    assign sck = sclk_b ^ ((g / 2) != 0);
    spi_sub_sync #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sck), .sdi(sdi), .sdo(sdo_all[g]),
      .tx_data(tx_data_b[7:0]), .tx_valid(txv[g]), .tx_ready(txr[g]),
      .rx_data(rxd8[g]), .rx_valid(rxv[g]), .busy(bsy[g]),
`ifdef SPI_SUB_FRAME_ERR_EN
      .frame_err(ferr[g]),
`endif
      .tx_underrun(und[g])
    );
  end

  spi_sub_sync #(.DATA_W(128), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk_b), .sdi(sdi), .sdo(sdo_all[4]),
    .tx_data(tx_data_b), .tx_valid(txv[4]), .tx_ready(txr[4]),
    .rx_data(rxd128), .rx_valid(rxv[4]), .busy(bsy[4]),
`ifdef SPI_SUB_FRAME_ERR_EN
    .frame_err(ferr[4]),
`endif
    .tx_underrun(und[4])
  );

`ifndef SPI_SUB_FRAME_ERR_EN
  assign ferr = '0;
`endif

  initial begin
    for (int k = 0; k < 5; k++) rxv_cnt[k] = 0;
    ferr_cnt = 0;
    rx0_last = '0;
    rx0_prev = '0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) if (rxv[k]) rxv_cnt[k] <= rxv_cnt[k] + 1;
    if (ferr[0]) ferr_cnt <= ferr_cnt + 1;
    if (rxv[0]) begin
      rx0_prev <= rx0_last;
      rx0_last <= rxd8[0];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b1; sclk_b = 1'b0; sdi = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic push(input int idx, input logic [127:0] d);
    logic ok;
    ok = 1'b0;
    tx_data_b = d;
    txv[idx] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (txr[idx]) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(1);
    txv[idx] = 1'b0;
    check("push_accept", {127'd0, ok}, 128'd1);
  endtask

  task automatic cs_low();
    for (int k = 0; k < 5; k++) begin
      mis_lead[k] = '0;
      mis_trail[k] = '0;
    end
    cs = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    tick(3);
    sdi = b;
    tick(2);
    for (int k = 0; k < 5; k++) mis_lead[k] = {mis_lead[k][126:0], sdo_all[k]};
    sclk_b = 1'b1;
    tick(5);
    for (int k = 0; k < 5; k++) mis_trail[k] = {mis_trail[k][126:0], sdo_all[k]};
    sclk_b = 1'b0;
  endtask

  task automatic cs_high();
    tick(5);
    cs = 1'b1;
    tick(10);
  endtask

  task automatic xfer(input int n, input logic [127:0] mosi);
    cs_low();
    for (int i = 0; i < n; i++) send_bit(mosi[n-1-i]);
    cs_high();
  endtask

  initial begin
    int c0, c4, f0;
    logic [127:0] miso;
    txv = '0;
    tx_data_b = '0;
    do_reset();

    check("rst_outs8", {123'd0, sdo_all[0], txr[0], rxv[0], bsy[0], und[0]}, 128'b01000);
    check("rst_rx8", {120'd0, rxd8[0]}, 128'd0);
    check("rst_outs128", {123'd0, sdo_all[4], txr[4], rxv[4], bsy[4], und[4]}, 128'b01000);
    check("rst_rx128", rxd128, 128'd0);

    push(4, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_hold_full", {127'd0, txr[4]}, 128'd0);
    c4 = rxv_cnt[4];
    xfer(128, 128'h00112233445566778899AABBCCDDEEFF);
    check("t1_rx", rxd128, 128'h00112233445566778899AABBCCDDEEFF);
    check("t1_rxv_cnt", 128'(rxv_cnt[4] - c4), 128'd1);
    check("t1_miso", mis_lead[4], 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_underrun", {127'd0, und[4]}, 128'd0);
    check("t1_busy", {127'd0, bsy[4]}, 128'd0);

    do_reset();
    for (int k = 0; k < 4; k++) push(k, 128'hA5);
    xfer(8, 128'h3C);
    for (int k = 0; k < 4; k++) begin
      miso = (k % 2 != 0) ? mis_trail[k] : mis_lead[k];
      check($sformatf("t2_rx_m%0d", k), {120'd0, rxd8[k]}, 128'h3C);
      check($sformatf("t2_miso_m%0d", k), {120'd0, miso[7:0]}, 128'hA5);
      check($sformatf("t2_und_m%0d", k), {127'd0, und[k]}, 128'd0);
    end

    push(0, 128'h11);
    c0 = rxv_cnt[0];
    fork
      xfer(16, 128'hC37E);
      begin
        tick(20);
        push(0, 128'h22);
      end
    join
    check("t3_rxv_cnt", 128'(rxv_cnt[0] - c0), 128'd2);
    check("t3_word1", {120'd0, rx0_prev}, 128'hC3);
    check("t3_word2", {120'd0, rx0_last}, 128'h7E);
    check("t3_miso", {112'd0, mis_lead[0][15:0]}, 128'h1122);
    check("t3_und", {127'd0, und[0]}, 128'd0);

    xfer(8, 128'h96);
    check("t4_miso", {120'd0, mis_lead[0][7:0]}, 128'h0);
    check("t4_und", {127'd0, und[0]}, 128'd1);
    check("t4_rx", {120'd0, rxd8[0]}, 128'h96);

    c0 = rxv_cnt[0];
    f0 = ferr_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
    check("t5_busy_mid", {127'd0, bsy[0]}, 128'd1);
    cs_high();
    check("t5_busy_end", {127'd0, bsy[0]}, 128'd0);
    check("t5_no_rxv", 128'(rxv_cnt[0] - c0), 128'd0);
    check("t5_rx_kept", {120'd0, rxd8[0]}, 128'h96);
`ifdef SPI_SUB_FRAME_ERR_EN
    check("t5_frame_err", 128'(ferr_cnt - f0), 128'd1);
`endif

    c0 = rxv_cnt[0];
    cs_low();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_n = 1'b0; cs = 1'b1; sclk_b = 1'b0; sdi = 1'b0;
    tick(3);
    check("t6_rst_outs", {123'd0, sdo_all[0], txr[0], rxv[0], bsy[0], und[0]}, 128'b01000);
    check("t6_rst_rx", {120'd0, rxd8[0]}, 128'd0);
    rst_n = 1'b1;
    tick(2);
    check("t6_no_rxv", 128'(rxv_cnt[0] - c0), 128'd0);
    push(0, 128'hE1);
    c0 = rxv_cnt[0];
    xfer(8, 128'h5A);
    check("t6_rx", {120'd0, rxd8[0]}, 128'h5A);
    check("t6_rxv_cnt", 128'(rxv_cnt[0] - c0), 128'd1);
    check("t6_miso", {120'd0, mis_lead[0][7:0]}, 128'hE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
